// File: rtl/strided_dma.sv
// Single-channel strided memory-to-memory copy engine: keeps up to FIFO_DEPTH
// reads in flight and streams buffered responses out as writes.
module strided_dma #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] src_stride,
    input  logic [ADDR_W-1:0] dst_stride,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  words_done,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    output logic              write_valid,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic              write_ready
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int SPACE_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
    logic [LEN_W-1:0]    words_done_q, words_done_d, reads_issued_q, reads_issued_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                req_valid_q, req_valid_d, write_valid_q, write_valid_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d, write_addr_q, write_addr_d;
    logic [ADDR_W-1:0]   src_stride_q, src_stride_d, dst_stride_q, dst_stride_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d, fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];

    logic                req_hs, wr_hs, resp_take, push, pop;
    logic [DATA_W-1:0]   head;
    logic [SPACE_W-1:0]  space_used;

    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        done_d         = done_q;
        aborted_d      = aborted_q;
        words_done_d   = words_done_q;
        reads_issued_d = reads_issued_q;
        len_d          = len_q;
        req_valid_d    = req_valid_q;
        req_addr_d     = req_addr_q;
        write_valid_d  = write_valid_q;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        src_stride_d   = src_stride_q;
        dst_stride_d   = dst_stride_q;

        req_hs    = req_valid_q & req_ready;
        wr_hs     = write_valid_q & write_ready;
        resp_take = resp_valid & (outstanding_q != '0);
        push      = resp_take & (state_q == RUN);
        pop       = wr_hs & (state_q == RUN);

        outstanding_d = outstanding_q + CNT_W'(req_hs) - CNT_W'(resp_take);
        fifo_count_d  = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d      = wr_ptr_q + PTR_W'(push);
        rd_ptr_d      = rd_ptr_q + PTR_W'(pop);

        if (req_hs) begin
            reads_issued_d = reads_issued_q + LEN_W'(1);
            req_addr_d     = req_addr_q + src_stride_q;
        end
        if (wr_hs) begin
            words_done_d = words_done_q + LEN_W'(1);
            write_addr_d = write_addr_q + dst_stride_q;
        end

        // A push landing in an empty (or just-emptied) FIFO becomes the head directly.
        head       = (push && (fifo_count_q == CNT_W'(pop))) ? resp_data : fifo_mem_q[rd_ptr_d];
        space_used = {1'b0, outstanding_d} + {1'b0, fifo_count_d};

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d          = len;
                    src_stride_d   = src_stride;
                    dst_stride_d   = dst_stride;
                    req_addr_d     = src_addr;
                    write_addr_d   = dst_addr;
                    reads_issued_d = '0;
                    words_done_d   = '0;
                    aborted_d      = 1'b0;
                    done_d         = (len == '0);
                    busy_d         = (len != '0);
                    req_valid_d    = (len != '0);
                    state_d        = (len != '0) ? RUN : IDLE;
                end
            end
            RUN: begin
                if (wr_hs && (words_done_d == len_q)) begin
                    state_d       = IDLE;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    req_valid_d   = 1'b0;
                    write_valid_d = 1'b0;
                end else if (abort) begin
                    state_d       = DRAIN;
                    fifo_count_d  = '0;
                    rd_ptr_d      = '0;
                    wr_ptr_d      = '0;
                    req_valid_d   = req_valid_q & ~req_ready;
                    write_valid_d = write_valid_q & ~write_ready;
                end else begin
                    write_valid_d = (fifo_count_d != '0);
                    write_data_d  = head;
                    // Only present a read whose response already has a FIFO slot reserved.
                    if (!req_valid_q || req_hs) begin
                        req_valid_d = (reads_issued_d < len_q) &&
                                      (space_used < SPACE_W'(FIFO_DEPTH));
                    end
                end
            end
            DRAIN: begin
                req_valid_d   = req_valid_q & ~req_ready;
                write_valid_d = write_valid_q & ~write_ready;
                if (!req_valid_q && !write_valid_q && (outstanding_q == '0)) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
            words_done_q   <= '0;
            reads_issued_q <= '0;
            len_q          <= '0;
            req_valid_q    <= 1'b0;
            req_addr_q     <= '0;
            write_valid_q  <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            src_stride_q   <= '0;
            dst_stride_q   <= '0;
            outstanding_q  <= '0;
            fifo_count_q   <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            aborted_q      <= aborted_d;
            words_done_q   <= words_done_d;
            reads_issued_q <= reads_issued_d;
            len_q          <= len_d;
            req_valid_q    <= req_valid_d;
            req_addr_q     <= req_addr_d;
            write_valid_q  <= write_valid_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
            src_stride_q   <= src_stride_d;
            dst_stride_q   <= dst_stride_d;
            outstanding_q  <= outstanding_d;
            fifo_count_q   <= fifo_count_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= resp_data;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign words_done  = words_done_q;
    assign req_valid   = req_valid_q;
    assign req_addr    = req_addr_q;
    assign write_valid = write_valid_q;
    assign write_addr  = write_addr_q;
    assign write_data  = write_data_q;
endmodule

// File: tb/tb_strided_dma.sv
// Randomized bench for strided_dma: a bus responder plus an address/data
// sequence model derived from base + index*stride arithmetic.
module tb_strided_dma;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int FD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, abort, req_ready, resp_valid, write_ready;
    logic [AW-1:0] src_addr, dst_addr, src_stride, dst_stride;
    logic [LW-1:0] len;
    logic [DW-1:0] resp_data;
    logic          busy, done, aborted, req_valid, write_valid;
    logic [LW-1:0] words_done;
    logic [AW-1:0] req_addr, write_addr;
    logic [DW-1:0] write_data;

    strided_dma #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr),
        .src_stride(src_stride), .dst_stride(dst_stride), .len(len),
        .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .write_valid(write_valid), .write_addr(write_addr), .write_data(write_data),
        .write_ready(write_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
    } rd_t;
    rd_t rq[$];

    logic [AW-1:0] c_src, c_dst, c_ss, c_ds;
    int            c_len;
    int            rr_pct, wr_pct, resp_pct;
    int            wr_block_until, abort_at_wr, abort_cyc, stall_chk_cyc;
    int            cyc = 0;
    int            start_cyc, complete_cyc;
    int            rd_cnt, wr_cnt, max_fill, last_rd_cyc, wr_at_abort, rd_at_abort;
    bit            do_start, in_xfer, aborting, ab_wr_allow, ab_rd_allow, idle_traffic;
    logic [31:0]   salt;
    logic          prev_rv, prev_rr, prev_wv, prev_wr;
    logic [AW-1:0] prev_ra, prev_wa;
    logic [DW-1:0] prev_wd;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] r;
        r = a * 32'h9E37_79B1;
        return r ^ salt;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input logic [31:0] stride,
                                             input int k);
        logic [31:0] kk;
        logic [31:0] r;
        kk = 32'(k);
        r  = base + kk * stride;
        return r;
    endfunction

    task automatic cycle();
        bit  rhs, whs;
        rd_t e;
        @(negedge clk);
        cyc++;
        if (prev_rv && !prev_rr)
            check("req_hold", {31'd0, req_valid, req_addr}, {31'd0, 1'b1, prev_ra});
        if (prev_wv && !prev_wr) begin
            check("wr_hold_addr", {31'd0, write_valid, write_addr}, {31'd0, 1'b1, prev_wa});
            check("wr_hold_data", 64'(write_data), 64'(prev_wd));
        end
        if (in_xfer && cyc == start_cyc + 1) begin
            check("first_busy", 64'(busy), 64'(c_len != 0));
            check("first_done", 64'(done), 64'(c_len == 0));
            check("first_aborted", 64'(aborted), 64'd0);
            check("first_reqv", 64'(req_valid), 64'(c_len != 0));
            check("first_wdone", 64'(words_done), 64'd0);
            if (c_len != 0) check("first_raddr", 64'(req_addr), 64'(c_src));
        end
        if (complete_cyc != 0 && cyc == complete_cyc + 1) begin
            check("cmpl_busy", 64'(busy), 64'd0);
            check("cmpl_done", 64'(done), 64'd1);
            check("cmpl_wdone", 64'(words_done), 64'(c_len));
        end
        if (stall_chk_cyc != 0 && cyc == stall_chk_cyc) begin
            check("stall_reads", 64'(rd_cnt), 64'(FD));
            check("stall_reqv", 64'(req_valid), 64'd0);
        end
        if (!busy && (req_valid || write_valid)) idle_traffic = 1;

        start      = 1'b0;
        abort      = 1'b0;
        src_addr   = $urandom;
        dst_addr   = $urandom;
        src_stride = $urandom;
        dst_stride = $urandom;
        len        = LW'($urandom);
        if (do_start) begin
            start      = 1'b1;
            abort      = 1'($urandom_range(1));
            src_addr   = c_src;
            dst_addr   = c_dst;
            src_stride = c_ss;
            dst_stride = c_ds;
            len        = LW'(c_len);
            do_start   = 0;
            start_cyc  = cyc;
            in_xfer    = 1;
        end else if (in_xfer && busy && $urandom_range(9) == 0) begin
            start = 1'b1;
        end

        req_ready   = ($urandom_range(99) < rr_pct);
        write_ready = (cyc >= wr_block_until) && ($urandom_range(99) < wr_pct);
        resp_valid  = 1'b0;
        resp_data   = $urandom;
        if (rq.size() > 0 && rq[0].cyc < cyc && $urandom_range(99) < resp_pct) begin
            resp_valid = 1'b1;
            resp_data  = mem_word(rq[0].addr);
            void'(rq.pop_front());
        end else if (rq.size() == 0 && $urandom_range(19) == 0) begin
            resp_valid = 1'b1;
        end

        rhs = req_valid && req_ready;
        whs = write_valid && write_ready;
        if (in_xfer && busy && !aborting && (wr_cnt + int'(whs)) < c_len &&
            ((abort_at_wr != 0 && whs && wr_cnt + 1 == abort_at_wr) ||
             (abort_cyc != 0 && cyc == abort_cyc))) begin
            abort       = 1'b1;
            aborting    = 1;
            ab_wr_allow = write_valid && !write_ready;
            ab_rd_allow = req_valid && !req_ready;
            wr_at_abort = wr_cnt + int'(whs);
            rd_at_abort = rd_cnt + int'(rhs);
        end

        if (rhs) begin
            check("rd_addr", 64'(req_addr), 64'(exp_addr(c_src, c_ss, rd_cnt)));
            e.cyc  = cyc;
            e.addr = req_addr;
            rq.push_back(e);
            rd_cnt++;
            last_rd_cyc = cyc;
        end
        if (whs) begin
            check("wr_addr", 64'(write_addr), 64'(exp_addr(c_dst, c_ds, wr_cnt)));
            check("wr_data", 64'(write_data), 64'(mem_word(exp_addr(c_src, c_ss, wr_cnt))));
            wr_cnt++;
            if (!aborting && wr_cnt == c_len) complete_cyc = cyc;
        end
        if (!aborting && (rd_cnt - wr_cnt) > max_fill) max_fill = rd_cnt - wr_cnt;

        prev_rv = req_valid;   prev_rr = req_ready;   prev_ra = req_addr;
        prev_wv = write_valid; prev_wr = write_ready; prev_wa = write_addr; prev_wd = write_data;
    endtask

    task automatic run_xfer(input string name, input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] ss, input logic [31:0] ds, input int n,
                            input int rrp, input int wrp, input int rsp,
                            input int abort_wr, input int abort_dly, input int wr_block);
        int budget;
        int exp_wd, exp_rd;
        bit fast;
        c_src = s; c_dst = d; c_ss = ss; c_ds = ds; c_len = n;
        rr_pct = rrp; wr_pct = wrp; resp_pct = rsp;
        fast = (rrp == 100) && (wrp == 100) && (rsp == 100) && (wr_block == 0);
        rd_cnt = 0; wr_cnt = 0; max_fill = 0; complete_cyc = 0; last_rd_cyc = 0;
        aborting = 0; ab_wr_allow = 0; ab_rd_allow = 0; idle_traffic = 0;
        wr_at_abort = 0; rd_at_abort = 0;
        abort_at_wr = abort_wr; abort_cyc = 0; stall_chk_cyc = 0; wr_block_until = 0;
        salt = $urandom;
        do_start = 1;
        cycle();
        abort_cyc      = (abort_dly != 0) ? start_cyc + abort_dly : 0;
        wr_block_until = start_cyc + wr_block;
        stall_chk_cyc  = (wr_block >= 20) ? start_cyc + 20 : 0;
        budget = 0;
        do begin
            cycle();
            budget++;
        end while ((busy || cyc <= start_cyc + 1) && budget < 5000);
        if (budget >= 5000) check("timeout", 64'd1, 64'd0);
        in_xfer = 0;
        repeat (3) cycle();
        exp_wd = aborting ? wr_at_abort + int'(ab_wr_allow) : n;
        exp_rd = aborting ? rd_at_abort + int'(ab_rd_allow) : n;
        check("end_done", 64'(done), 64'd1);
        check("end_aborted", 64'(aborted), 64'(aborting));
        check("end_wdone", 64'(words_done), 64'(exp_wd));
        check("write_count", 64'(wr_cnt), 64'(exp_wd));
        check("read_count", 64'(rd_cnt), 64'(exp_rd));
        check("drained", 64'(rq.size()), 64'd0);
        check("idle_traffic", 64'(idle_traffic), 64'd0);
        check("fill_bound", 64'(max_fill <= FD), 64'd1);
        if (fast && !aborting && n > 0) check("back2back", 64'(last_rd_cyc - start_cyc), 64'(n));
        $display("xfer %s len=%0d src=%h dst=%h ss=%h ds=%h writes=%0d aborted=%0d",
                 name, n, s, d, ss, ds, wr_cnt, aborting);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_flags"}, {44'd0, busy, done, aborted, req_valid, write_valid, words_done},
              64'd0);
        check({tag, "_addrs"}, {req_addr, write_addr}, 64'd0);
        check({tag, "_data"}, 64'(write_data), 64'd0);
    endtask

    task automatic idle_abort();
        logic was_ab;
        was_ab = aborted;
        @(negedge clk);
        cyc++;
        abort = 1'b1;
        cycle();
        check("idle_abort_done", 64'(done), 64'd1);
        check("idle_abort_flag", 64'(aborted), 64'(was_ab));
        check("idle_abort_busy", 64'(busy), 64'd0);
        $display("idle abort: done=%0d aborted=%0d", done, aborted);
    endtask

    task automatic reset_mid();
        int guard;
        c_src = 32'h4000; c_dst = 32'h5000; c_ss = 4; c_ds = 4; c_len = 10;
        rr_pct = 50; wr_pct = 50; resp_pct = 50;
        abort_at_wr = 0; abort_cyc = 0; stall_chk_cyc = 0; wr_block_until = 0;
        rd_cnt = 0; wr_cnt = 0; complete_cyc = 0; aborting = 0;
        do_start = 1;
        cycle();
        repeat (4) cycle();
        guard = 0;
        while (!req_valid && guard < 50) begin
            cycle();
            guard++;
        end
        check("rst_mid_reqv", 64'(req_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk); cyc++;
        @(negedge clk); cyc++;
        check_zero_outputs("rst_mid");
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'hDEAD_BEEF;
        rq.delete();
        in_xfer = 0;
        prev_rv = 1'b0;
        prev_wv = 1'b0;
        $display("reset mid-transfer: outputs cleared, stale response driven");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; req_ready = 1'b0; write_ready = 1'b0;
        resp_valid = 1'b0; resp_data = '0; src_addr = '0; dst_addr = '0;
        src_stride = '0; dst_stride = '0; len = '0;
        prev_rv = 0; prev_wv = 0; prev_rr = 0; prev_wr = 0;
        prev_ra = '0; prev_wa = '0; prev_wd = '0;
        in_xfer = 0; do_start = 0; salt = 0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        run_xfer("basic", 32'h1000, 32'h2000, 4, 4, 4, 100, 100, 100, 0, 0, 0);
        run_xfer("wr_stall", 32'h1100, 32'h2100, 4, 4, 10, 100, 100, 100, 0, 0, 20);
        run_xfer("neg_stride", 32'h3000, 32'h8, 32'h10, 32'hFFFF_FFFC, 3, 60, 60, 60, 0, 0, 0);
        run_xfer("len0", 32'h1000, 32'h2000, 4, 4, 0, 100, 100, 100, 0, 0, 0);
        idle_abort();
        run_xfer("abort3", 32'h6000, 32'h7000, 4, 4, 8, 100, 100, 100, 3, 0, 0);
        check("abort3_wdone", 64'(words_done), 64'd3);
        idle_abort();
        run_xfer("after_abort", 32'h6100, 32'h7100, 8, 4, 5, 70, 70, 70, 0, 0, 0);
        reset_mid();
        run_xfer("post_reset", 32'hA000, 32'hB000, 4, 4, 2, 100, 100, 100, 0, 0, 0);

        for (int t = 0; t < 14; t++) begin
            int n, mode, aw, ad;
            n    = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(24, 1));
            mode = int'($urandom_range(2));
            aw   = (mode == 1 && n > 0) ? int'($urandom_range(n, 1)) : 0;
            ad   = (mode == 2) ? int'($urandom_range(40, 2)) : 0;
            run_xfer($sformatf("rand%0d", t), $urandom, $urandom,
                     ($urandom_range(1) == 0) ? 32'($urandom_range(64)) : $urandom,
                     ($urandom_range(1) == 0) ? 32'($urandom_range(64)) : $urandom,
                     n, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                     int'($urandom_range(100, 30)), aw, ad, int'($urandom_range(10)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
